// File: rtl/core_arb_pkg.sv
// rtl/core_arb_pkg.sv - shared types and constants for the dual-core arbiter
//
// Purpose : command encoding, stall-count type and core indices used by
//           core_arbiter and stall_counter.
// Ports   : none (package).
package core_arb_pkg;

   typedef logic [2:0] stall_t;

   // Pause/resume command as emitted by each core: {valid, run_value, target}.
   typedef struct packed {
      logic valid;
      logic run_value;
      logic target;
   } pr_cmd_t;

   localparam logic CORE1 = 1'b0;
   localparam logic CORE2 = 1'b1;

   // Largest count a stall_t can hold; parameters above this are rejected.
   localparam int unsigned STALL_MAX = 7;

endpackage

// File: rtl/stall_counter.sv
// rtl/stall_counter.sv - loadable 3-bit saturating down-counter
//
// Purpose : per-core conflict stall counter. Loads on i_load, otherwise
//           decrements by one per cycle and holds at zero.
// Ports   : clk        - clock
//           rst        - asynchronous active-high reset (count -> 0)
//           i_load     - load i_load_val this cycle
//           i_load_val - value to load
//           o_count    - current count
//           o_busy     - count is nonzero
module stall_counter
   import core_arb_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_load,
   input  stall_t i_load_val,
   output stall_t o_count,
   output logic   o_busy
);

   stall_t r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (r_count != '0) begin
         r_count <= r_count - 3'd1;
      end
   end

   assign o_count = r_count;
   assign o_busy  = (r_count != '0);

endmodule

// File: rtl/core_arbiter.sv
// rtl/core_arbiter.sv - registered pause/resume and port-conflict arbiter for two cores
//
// Purpose : owns the two-bit run register, resolves simultaneous read/write
//           conflicts between the cores and presents per-core stall counts.
//           Optional macro CORE_ARB_RR_EN selects round-robin winner
//           selection; without it core 1 always wins.
// Ports   : clk            - clock, all state on posedge
//           rst            - asynchronous active-high reset
//           pr_1, pr_2     - pause/resume commands {valid, run_value, target}
//           rd_1, rd_2     - data-read requests
//           wen_1, wen_2   - write requests
//           run            - run state, bit 0 = core 1, bit 1 = core 2
//           stall_1/2      - stall count per core, 0 = proceed
module core_arbiter
   import core_arb_pkg::*;
#(
   parameter int unsigned STALL_PR = 6,
   parameter int unsigned STALL_WR = 6,
   parameter int unsigned STALL_RD = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] pr_1,
   input  logic [2:0] pr_2,
   input  logic       rd_1,
   input  logic       rd_2,
   input  logic       wen_1,
   input  logic       wen_2,
   output logic [1:0] run,
   output logic [2:0] stall_1,
   output logic [2:0] stall_2
);

   generate
      if (STALL_PR > STALL_MAX || STALL_WR > STALL_MAX || STALL_RD > STALL_MAX) begin : g_cfg_err
         $error("core_arbiter: stall parameters must not exceed 7");
      end
   endgenerate

   localparam stall_t LP_PR = stall_t'(STALL_PR);
   localparam stall_t LP_WR = stall_t'(STALL_WR);
   localparam stall_t LP_RD = stall_t'(STALL_RD);

   logic [1:0] r_run;
   logic [1:0] w_run_nxt;
   pr_cmd_t    w_cmd1;
   pr_cmd_t    w_cmd2;
   logic       w_busy1;
   logic       w_busy2;
   stall_t     w_cnt1;
   stall_t     w_cnt2;
   logic       w_contend;
   logic       w_wr_conf;
   logic       w_rd_conf;
   logic       w_conf;
   logic       w_winner;
   logic       w_load1;
   logic       w_load2;
   stall_t     w_load_val;

   // A paused core is not executing, so its commands are not honoured;
   // this is why a self-paused core needs the other core to resume it.
   // Core 2's command is applied first so core 1 overrides on a shared target.
   always_comb begin
      w_cmd1    = pr_cmd_t'(pr_1);
      w_cmd2    = pr_cmd_t'(pr_2);
      w_run_nxt = r_run;
      if (w_cmd2.valid && r_run[CORE2]) begin
         w_run_nxt[w_cmd2.target] = w_cmd2.run_value;
      end
      if (w_cmd1.valid && r_run[CORE1]) begin
         w_run_nxt[w_cmd1.target] = w_cmd1.run_value;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run <= 2'b01;
      end else begin
         r_run <= w_run_nxt;
      end
   end

   // Only a cycle in which both cores are live and neither is already
   // serving a conflict stall can produce a new conflict.
   always_comb begin
      w_contend  = (r_run == 2'b11) && !w_busy1 && !w_busy2;
      w_wr_conf  = w_contend && wen_1 && wen_2;
      w_rd_conf  = w_contend && rd_1 && rd_2 && !w_wr_conf;
      w_conf     = w_wr_conf || w_rd_conf;
      w_load_val = w_wr_conf ? LP_WR : LP_RD;
      w_load1    = w_conf && (w_winner == CORE2);
      w_load2    = w_conf && (w_winner == CORE1);
   end

`ifdef CORE_ARB_RR_EN
   logic r_rr;

   // Pointer names the core favoured next; it moves to the loser.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr <= CORE1;
      end else if (w_conf) begin
         r_rr <= ~r_rr;
      end
   end

   assign w_winner = r_rr;
`else
   assign w_winner = CORE1;
`endif

   stall_counter u_cnt1 (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load1),
      .i_load_val (w_load_val),
      .o_count    (w_cnt1),
      .o_busy     (w_busy1)
   );

   stall_counter u_cnt2 (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load2),
      .i_load_val (w_load_val),
      .o_count    (w_cnt2),
      .o_busy     (w_busy2)
   );

   // Pause masks the counter, which keeps running underneath.
   assign run     = r_run;
   assign stall_1 = r_run[CORE1] ? w_cnt1 : LP_PR;
   assign stall_2 = r_run[CORE2] ? w_cnt2 : LP_PR;

endmodule
